// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO: default sizes,
// the count-width helper and the status bundle used by monitors.
package fifo_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 16;

    // Occupancy must be able to represent every value from 0 up to DEPTH inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    localparam fifo_status_t STATUS_RESET = '{
        empty:        1'b1,
        full:         1'b0,
        almost_full:  1'b0,
        almost_empty: 1'b1,
        overflow:     1'b0,
        underflow:    1'b0
    };

endpackage

// File: rtl/fifo_ram.sv
// FIFO storage array: one synchronous write port and one combinational read
// port, so the same array serves both registered and fall-through read modes.
module fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO with occupancy count, thresholds and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered read.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           in,
    input  logic                       clr_err,
    output logic [WIDTH-1:0]           out,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int CW = cnt_width(DEPTH);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C     = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C     = CW'(AE_LEVEL);

    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    fifo_status_t     status_q, status_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             pushAcc, popAcc;
    logic [PW-1:0]    raddr;
    logic [WIDTH-1:0] rdata;

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_ram (
        .clk   (clk),
        .we    (pushAcc),
        .waddr (wptr_q),
        .wdata (in),
        .raddr (raddr),
        .rdata (rdata)
    );

`ifdef SYNC_FIFO_FWFT_EN
    // The out register is loaded with the word that will be at the head after this edge.
    assign raddr = rptr_d;
`else
    assign raddr = rptr_q;
`endif

    always_comb begin
        pushAcc = push && !status_q.full;
        popAcc  = pop && !status_q.empty;

        wptr_d = wptr_q;
        if (pushAcc) begin
            wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + PW'(1);
        end

        rptr_d = rptr_q;
        if (popAcc) begin
            rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + PW'(1);
        end

        count_d = count_q;
        if (pushAcc && !popAcc) begin
            count_d = count_q + CW'(1);
        end else if (popAcc && !pushAcc) begin
            count_d = count_q - CW'(1);
        end

        // Flags are registered from the next-state count so they move with the data.
        status_d.empty        = (count_d == '0);
        status_d.full         = (count_d == DEPTH_C);
        status_d.almost_full  = (count_d >= AF_C);
        status_d.almost_empty = (count_d <= AE_C);
        status_d.overflow     = (push && status_q.full) || (status_q.overflow && !clr_err);
        status_d.underflow    = (pop && status_q.empty) || (status_q.underflow && !clr_err);

        out_d = out_q;
`ifdef SYNC_FIFO_FWFT_EN
        // When the only word left after this edge is the one being written, bypass the array.
        if (count_d != '0) begin
            if (pushAcc && (count_q == CW'(popAcc))) begin
                out_d = in;
            end else begin
                out_d = rdata;
            end
        end
`else
        if (popAcc) begin
            out_d = rdata;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            status_q <= STATUS_RESET;
            out_q    <= '0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            status_q <= status_d;
            out_q    <= out_d;
        end
    end

    assign out          = out_q;
    assign count        = count_q;
    assign empty        = status_q.empty;
    assign full         = status_q.full;
    assign almost_full  = status_q.almost_full;
    assign almost_empty = status_q.almost_empty;
    assign overflow     = status_q.overflow;
    assign underflow    = status_q.underflow;

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised synchronous FIFO for the video datapath. It replaces the fixed single-port-pair FIFO with a version that adds:
- configurable width and arbitrary (non-power-of-2) depth;
- occupancy count and programmable almost-full/almost-empty thresholds;
- simultaneous push/pop, plus sticky overflow/underflow error flags;
- optional first-word-fall-through read mode.

It sits between pixel-stream producers and consumers running on the same clock.

## Interface
- WIDTH, 8, data width in bits (≥1)
- DEPTH, 16, number of entries (≥2, any integer)
- AF_LEVEL, DEPTH-2, almost_full asserts when count ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL (0..DEPTH-1)
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- push  in  1  write request
- pop  in  1  read request
- in  in  WIDTH  write data, sampled on an accepted push
- clr_err  in  1  clears overflow/underflow
- out  out  WIDTH  read data
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- count  out  $clog2(DEPTH+1)  current occupancy
- overflow  out  1  sticky: push while full
- underflow  out  1  sticky: pop while empty

## Operation
- **Push acceptance:** a push is accepted iff push && !full. An accepted push writes `in` to mem[wptr], and wptr advances.
- **Pop acceptance:** a pop is accepted iff pop && !empty. An accepted pop advances rptr.
- **Pointer wrap:** both pointers wrap DEPTH-1 → 0. Explicit compare; no power-of-2 assumption.
- **Count:** +1 on push-only, −1 on pop-only. Unchanged when both are accepted, or when neither is.
- **Simultaneous push+pop:**
  - At 0 < count < DEPTH, both are accepted.
  - When full, only the pop is accepted; the push is dropped and overflow is set.
  - When empty, only the push is accepted; underflow is set.
- **Rejected requests:** a rejected push or pop leaves pointers, count and memory unchanged.
- **Error flags:** overflow/underflow set on the edge after the offending request.
  - They hold until clr_err is sampled high.
  - If a new error occurs in the same cycle as clr_err, set wins.
- **Status flags:** all flags are registered, derived from next-state count.
- **Reset values:**
  - count=0, empty=1, full=0, almost_empty=1, almost_full=0
  - overflow=0, underflow=0, out=0, wptr=rptr=0
- **Reset mid-operation:** discards all contents immediately (asynchronous). Memory contents are not cleared.

## Timing
- **Standard mode:** `out` is registered. It loads mem[rptr] on the edge that accepts a pop and is valid from that edge on (1-cycle read latency). `out` holds between pops.
- **Flags:** flags and count update on the same edge as the accepted operation.
- **Write-to-read latency:** pop may be issued in the cycle after the push edge (empty already deasserted).
- **Throughput:** one push and one pop per cycle, sustained.

## Configuration
- **With SYNC_FIFO_FWFT_EN defined:** first-word-fall-through mode.
  - `out` presents mem[rptr] whenever !empty, with no pop required.
  - The first word is visible on the edge after its push.
  - pop acknowledges the current word; the next word appears on the following edge.
  - While empty, `out` holds its last value (0 after reset).
- **Without SYNC_FIFO_FWFT_EN:** standard registered-read mode as described under Operation/Timing.
- Flags, count and error behaviour are identical in both modes.

## Structure
- **Shared package fifo_pkg:**
  - default WIDTH/DEPTH constants;
  - count-width function (clog2 of DEPTH+1);
  - typedef of the status bundle {empty, full, almost_full, almost_empty, overflow, underflow} for monitors.
- **Sub-module fifo_ram:** storage array with
  - one synchronous write port (we, waddr, wdata);
  - one read port (raddr, rdata), combinational read, so the same storage serves both modes.
- **Top level:** pointers, count, flags and the out register.

## Test plan
- **Reset and basic order** (WIDTH=8, DEPTH=5): push 0x11, 0x22, 0x33, then pop ×3 → out = 0x11, 0x22, 0x33 in order; count 3→0; empty=1 at end.
- **Full and overflow:** push 0x00..0x05 on consecutive cycles → full=1 after the 5th push; the 6th push is dropped; overflow=1; count=5; a later pop returns 0x00 first. clr_err → overflow=0.
- **Underflow:** from reset, pop=1 for one cycle → underflow=1, count stays 0, out stays 0. clr_err and pop asserted together on an empty FIFO → underflow stays 1.
- **Wrap-around at DEPTH=5:** 12 cycles of interleaved push/pop carrying data 1..12 → pointers cross 4→0 twice; all 12 words read back in order; no error flags.
- **Simultaneous push+pop:**
  - At count=3: count stays 3, and the popped word is the oldest entry.
  - At full: count 5→4, overflow=1.
  - At empty: count 0→1, underflow=1.
- **Thresholds and async reset** (AF_LEVEL=4, AE_LEVEL=1):
  - almost_full rises on the push making count=4.
  - almost_empty falls when count reaches 2.
  - reset asserted mid-clock-period at count=3 → count=0 and empty=1 immediately, before the next edge.
